// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs one request/grant/rvalid bus transaction per
// memory instruction, aligns store data, extends load data, registers write-back.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] reg_wdata_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_rdata_i,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] reg_wdata_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    ldf3_q, ldf3_d;
    logic [4:0]    lwaddr_q, lwaddr_d;
    logic          lwe_q, lwe_d;
    logic          bwe_q, bwe_d;
    logic [31:0]   baddr_q, baddr_d;
    logic [31:0]   bwdata_q, bwdata_d;
    logic [3:0]    bbe_q, bbe_d;
    logic [31:0]   rwdata_q, rwdata_d;
    logic          rwe_q, rwe_d;
    logic [4:0]    rwaddr_q, rwaddr_d;
    logic          mis_q, mis_d;
    logic          err_q, err_d;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        is_load, is_store, is_bubble, misal, mem_go, expire;
    logic [31:0] shifted, ld_data;
    logic        unused_inst;

    assign opcode      = inst_i[6:0];
    assign f3          = inst_i[14:12];
    assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

    // Decode: funct3 values outside the legal sets under a memory opcode are bubbles.
    always_comb begin
        is_load   = (opcode == OP_LOAD) &&
                    (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                     f3 == 3'b100 || f3 == 3'b101);
        is_store  = (opcode == OP_STORE) &&
                    (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        is_bubble = ((opcode == OP_LOAD) || (opcode == OP_STORE)) && !(is_load || is_store);
        misal     = (is_load || is_store) &&
                    (((f3[1:0] == 2'b10) && (mem_addr_i[1:0] != 2'b00)) ||
                     ((f3[1:0] == 2'b01) && mem_addr_i[0]));
        mem_go    = (is_load || is_store) && !misal;
    end

    assign expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        shifted = bus_rdata_i >> {off_q, 3'b000};
        case (ldf3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld_data = {24'h0, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Handshake is tested before expiry so a grant on the last cycle still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_go) state_d = REQ;
            REQ:     if (bus_gnt_i)    state_d = bwe_q ? DONE : WAIT_R;
                     else if (expire)  state_d = DONE;
            WAIT_R:  if (bus_rvalid_i || expire) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req_o   = (state_q == REQ);
        bus_we_o    = bwe_q;
        bus_addr_o  = baddr_q;
        bus_wdata_o = bwdata_q;
        bus_be_o    = bbe_q;
        reg_wdata_o = rwdata_q;
        reg_we_o    = rwe_q;
        reg_waddr_o = rwaddr_q;
        misalign_o  = mis_q;
        bus_err_o   = err_q;
        // Gated by reset so every output reads 0 while reset is held.
        stall_o     = rst && (((state_q == IDLE) && mem_go) ||
                              (state_q == REQ) || (state_q == WAIT_R));
    end

    always_comb begin
        cnt_d    = cnt_q;
        off_d    = off_q;
        ldf3_d   = ldf3_q;
        lwaddr_d = lwaddr_q;
        lwe_d    = lwe_q;
        bwe_d    = bwe_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        bbe_d    = bbe_q;
        rwdata_d = rwdata_q;
        rwe_d    = rwe_q;
        rwaddr_d = rwaddr_q;
        mis_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_go) begin
                    baddr_d  = {mem_addr_i[31:2], 2'b00};
                    bwe_d    = is_store;
                    off_d    = mem_addr_i[1:0];
                    ldf3_d   = f3;
                    lwaddr_d = reg_waddr_i;
                    lwe_d    = reg_we_i;
                    cnt_d    = '0;
                    rwe_d    = 1'b0;
                    case (f3[1:0])
                        2'b00: begin
                            bwdata_d = {4{reg2_rdata_i[7:0]}};
                            bbe_d    = 4'b0001 << mem_addr_i[1:0];
                        end
                        2'b01: begin
                            bwdata_d = {2{reg2_rdata_i[15:0]}};
                            bbe_d    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                        end
                        default: begin
                            bwdata_d = reg2_rdata_i;
                            bbe_d    = 4'b1111;
                        end
                    endcase
                end else if (misal) begin
                    mis_d = 1'b1;
                    rwe_d = 1'b0;
                end else if (is_bubble) begin
                    rwe_d = 1'b0;
                end else begin
                    rwdata_d = reg_wdata_i;
                    rwe_d    = reg_we_i;
                    rwaddr_d = reg_waddr_i;
                end
            end
            REQ: begin
                if (bus_gnt_i) begin
                    rwe_d = 1'b0;
                    cnt_d = '0;
                end else if (expire) begin
                    err_d = 1'b1;
                    rwe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_R: begin
                if (bus_rvalid_i) begin
                    rwdata_d = ld_data;
                    rwe_d    = lwe_q;
                    rwaddr_d = lwaddr_q;
                end else if (expire) begin
                    err_d = 1'b1;
                    rwe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: rwe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            off_q    <= '0;
            ldf3_q   <= '0;
            lwaddr_q <= '0;
            lwe_q    <= 1'b0;
            bwe_q    <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
            bbe_q    <= '0;
            rwdata_q <= '0;
            rwe_q    <= 1'b0;
            rwaddr_q <= '0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            ldf3_q   <= ldf3_d;
            lwaddr_q <= lwaddr_d;
            lwe_q    <= lwe_d;
            bwe_q    <= bwe_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            bbe_q    <= bbe_d;
            rwdata_q <= rwdata_d;
            rwe_q    <= rwe_d;
            rwaddr_q <= rwaddr_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: single-cycle vector table plus hand-written
// bus transaction, timeout and reset sequences.
module tb_mem_lsu;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, reg_wdata_i, mem_addr_i, reg2_rdata_i, bus_rdata_i;
    logic        reg_we_i, bus_gnt_i, bus_rvalid_i;
    logic [4:0]  reg_waddr_i;
    logic        bus_req_o, bus_we_o, reg_we_o, stall_o, misalign_o, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, reg_wdata_o;
    logic [3:0]  bus_be_o;
    logic [4:0]  reg_waddr_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .reg_wdata_i(reg_wdata_i),
        .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .mem_addr_i(mem_addr_i),
        .reg2_rdata_i(reg2_rdata_i), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
        .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] wd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] addr;
        logic        exp_we;
        logic        chk_wd;
        logic [31:0] exp_wd;
        logic [4:0]  exp_wa;
        logic        exp_mis;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'h0, f3, 5'h0, op};
    endfunction

    function automatic vec_t alu(input logic [4:0] wa, input logic we, input logic [31:0] wd);
        vec_t v;
        v = '{inst: mk(OP_ALU, 3'b000), wd: wd, we: we, wa: wa, addr: 32'h0,
              exp_we: we, chk_wd: 1'b1, exp_wd: wd, exp_wa: wa, exp_mis: 1'b0};
        return v;
    endfunction

    function automatic vec_t memv(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic mis);
        vec_t v;
        v = '{inst: mk(op, f3), wd: 32'hDEAD_BEEF, we: 1'b1, wa: 5'd3, addr: addr,
              exp_we: 1'b0, chk_wd: 1'b0, exp_wd: 32'h0, exp_wa: 5'd0, exp_mis: mis};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        inst_i       = mk(7'b0010011, 3'b000);
        reg_wdata_i  = 32'h0;
        reg_we_i     = 1'b0;
        reg_waddr_i  = 5'd0;
        mem_addr_i   = 32'h0;
        reg2_rdata_i = 32'h0;
    endtask

    task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input int gnt_wait,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        int req_cnt;
        inst_i = mk(OP_STORE, f3); mem_addr_i = addr; reg2_rdata_i = rs2;
        reg_we_i = 1'b1; reg_waddr_i = 5'd4;
        #1 chk({nm, "_stall_idle"}, 32'(stall_o), 32'd1);
        tick();
        chk({nm, "_req"}, 32'(bus_req_o), 32'd1);
        chk({nm, "_we"}, 32'(bus_we_o), 32'd1);
        chk({nm, "_addr"}, bus_addr_o, exp_addr);
        chk({nm, "_be"}, 32'(bus_be_o), 32'(exp_be));
        chk({nm, "_wdata"}, bus_wdata_o, exp_wdata);
        chk({nm, "_reg_we"}, 32'(reg_we_o), 32'd0);
        req_cnt = 1;
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            if (bus_req_o) req_cnt++;
        end
        chk({nm, "_addr_held"}, bus_addr_o, exp_addr);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk({nm, "_req_cycles"}, 32'(req_cnt), 32'(gnt_wait + 1));
        chk({nm, "_done_req"}, 32'(bus_req_o), 32'd0);
        chk({nm, "_done_stall"}, 32'(stall_o), 32'd0);
        chk({nm, "_done_reg_we"}, 32'(reg_we_o), 32'd0);
        chk({nm, "_done_err"}, 32'(bus_err_o), 32'd0);
        tick();
        set_nop();
        #1 chk({nm, "_idle_stall"}, 32'(stall_o), 32'd0);
    endtask

    task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
        inst_i = mk(OP_LOAD, f3); mem_addr_i = addr; reg_we_i = 1'b1;
        reg_waddr_i = 5'd9; reg_wdata_i = 32'h0000_DEAD;
        #1 chk({nm, "_stall_idle"}, 32'(stall_o), 32'd1);
        tick();
        chk({nm, "_req"}, 32'(bus_req_o), 32'd1);
        chk({nm, "_bus_we"}, 32'(bus_we_o), 32'd0);
        chk({nm, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
        chk({nm, "_be"}, 32'(bus_be_o), 32'(exp_be));
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk({nm, "_wait_req"}, 32'(bus_req_o), 32'd0);
        chk({nm, "_wait_stall"}, 32'(stall_o), 32'd1);
        chk({nm, "_wait_reg_we"}, 32'(reg_we_o), 32'd0);
        bus_rvalid_i = 1'b1; bus_rdata_i = rdata;
        tick();
        bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        chk({nm, "_wdata"}, reg_wdata_o, exp_wd);
        chk({nm, "_reg_we"}, 32'(reg_we_o), 32'd1);
        chk({nm, "_waddr"}, 32'(reg_waddr_o), 32'd9);
        chk({nm, "_done_stall"}, 32'(stall_o), 32'd0);
        tick();
        set_nop();
        chk({nm, "_we_drop"}, 32'(reg_we_o), 32'd0);
    endtask

    initial begin
        int req_cnt;
        rst = 1'b0;
        set_nop();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;

        tbl[0]  = alu(5'd5, 1'b1, 32'h1234);
        tbl[1]  = alu(5'd5, 1'b1, 32'h1234);
        tbl[2]  = alu(5'd5, 1'b1, 32'h1234);
        tbl[3]  = memv(OP_LOAD, 3'b001, 32'h2001, 1'b1);
        tbl[4]  = alu(5'd7, 1'b0, 32'hDEAD);
        tbl[5]  = alu(5'd6, 1'b1, 32'hCAFE);
        tbl[6]  = memv(OP_LOAD, 3'b010, 32'h2006, 1'b1);
        tbl[7]  = memv(OP_STORE, 3'b010, 32'h1001, 1'b1);
        tbl[8]  = alu(5'd1, 1'b1, 32'h1);
        tbl[9]  = memv(OP_STORE, 3'b001, 32'h1003, 1'b1);
        tbl[10] = alu(5'd2, 1'b1, 32'h2);
        tbl[11] = memv(OP_LOAD, 3'b011, 32'h0, 1'b0);
        tbl[12] = memv(OP_LOAD, 3'b101, 32'h3, 1'b1);
        tbl[13] = alu(5'd31, 1'b1, 32'hFFFF_FFFF);
        tbl[14] = memv(OP_STORE, 3'b100, 32'h0, 1'b0);

        #2;
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_reg_we", 32'(reg_we_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        tick(); tick();
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            inst_i = tbl[i].inst; reg_wdata_i = tbl[i].wd; reg_we_i = tbl[i].we;
            reg_waddr_i = tbl[i].wa; mem_addr_i = tbl[i].addr; reg2_rdata_i = 32'h5555_AAAA;
            #1 chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'd0);
            tick();
            chk($sformatf("vec%0d_reg_we", i), 32'(reg_we_o), 32'(tbl[i].exp_we));
            chk($sformatf("vec%0d_misalign", i), 32'(misalign_o), 32'(tbl[i].exp_mis));
            chk($sformatf("vec%0d_req", i), 32'(bus_req_o), 32'd0);
            if (tbl[i].chk_wd) begin
                chk($sformatf("vec%0d_wdata", i), reg_wdata_o, tbl[i].exp_wd);
                chk($sformatf("vec%0d_waddr", i), 32'(reg_waddr_o), 32'(tbl[i].exp_wa));
            end
        end
        set_nop();
        tick();
        chk("mis_pulse_end", 32'(misalign_o), 32'd0);

        do_store("sb", 3'b000, 32'h1003, 32'hAABB_CC80, 2, 32'h1000, 4'b1000, 32'h8080_8080);
        do_store("sh", 3'b001, 32'h1002, 32'h0000_BEEF, 0, 32'h1000, 4'b1100, 32'hBEEF_BEEF);
        do_store("sw_gnt_at_expiry", 3'b010, 32'h4000, 32'h1122_3344, 3, 32'h4000, 4'b1111,
                 32'h1122_3344);

        do_load("lb", 3'b000, 32'h2002, 32'h00F0_0000, 4'b0100, 32'hFFFF_FFF0);
        do_load("lbu", 3'b100, 32'h2002, 32'h00F0_0000, 4'b0100, 32'h0000_00F0);
        do_load("lh", 3'b001, 32'h2002, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h2000, 32'h1234_ABCD, 4'b0011, 32'h0000_ABCD);
        do_load("lw", 3'b010, 32'h2004, 32'h1234_5678, 4'b1111, 32'h1234_5678);

        // Store never granted: abort after TIMEOUT request cycles.
        inst_i = mk(OP_STORE, 3'b010); mem_addr_i = 32'h4000; reg2_rdata_i = 32'h1;
        reg_we_i = 1'b1;
        tick();
        req_cnt = 0;
        for (int i = 0; i < 10 && bus_req_o; i++) begin
            req_cnt++;
            chk("to_err_early", 32'(bus_err_o), 32'd0);
            tick();
        end
        chk("to_req_cycles", 32'(req_cnt), 32'd4);
        chk("to_err", 32'(bus_err_o), 32'd1);
        chk("to_reg_we", 32'(reg_we_o), 32'd0);
        chk("to_stall", 32'(stall_o), 32'd0);
        set_nop();
        tick();
        chk("to_err_pulse_end", 32'(bus_err_o), 32'd0);
        chk("to_idle_req", 32'(bus_req_o), 32'd0);

        // Reset in the middle of a load's read wait.
        inst_i = mk(OP_LOAD, 3'b010); mem_addr_i = 32'h5008; reg_we_i = 1'b1; reg_waddr_i = 5'd12;
        tick();
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk("rw_in_wait", 32'(stall_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rw_req", 32'(bus_req_o), 32'd0);
        chk("rw_stall", 32'(stall_o), 32'd0);
        chk("rw_addr", bus_addr_o, 32'h0);
        chk("rw_be_we", {27'h0, bus_be_o, bus_we_o}, 32'h0);
        chk("rw_wdata", bus_wdata_o, 32'h0);
        chk("rw_reg", {reg_we_o, reg_waddr_o, misalign_o, bus_err_o}, 32'h0);
        chk("rw_reg_wdata", reg_wdata_o, 32'h0);
        set_nop();
        tick();
        rst = 1'b1;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        tick();
        bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        chk("late_rvalid_we", 32'(reg_we_o), 32'd0);
        chk("late_rvalid_wdata", reg_wdata_o, 32'h0);
        chk("late_rvalid_req", 32'(bus_req_o), 32'd0);
        inst_i = mk(OP_ALU, 3'b000); reg_we_i = 1'b1; reg_waddr_i = 5'd5; reg_wdata_i = 32'h55;
        #1 chk("post_rst_add_stall", 32'(stall_o), 32'd0);
        tick();
        chk("post_rst_add_we", 32'(reg_we_o), 32'd1);
        chk("post_rst_add_wa", 32'(reg_waddr_o), 32'd5);
        chk("post_rst_add_wd", reg_wdata_o, 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit. Consumes the EX/MEM pipeline register outputs and runs the data-memory bus transaction.
- Bus is a request/grant/read-valid handshake.
- Aligns store data and byte enables; extracts and sign- or zero-extends load data.
- Registers the write-back triple for the MEM/WB boundary.
- Stalls upstream while a transaction is in flight.

Parameters:
- TIMEOUT, 255: max cycles waiting for bus_gnt_i or bus_rvalid_i before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- inst_i  in  32  instruction (opcode [6:0], funct3 [14:12])
- reg_wdata_i  in  32  ALU write-back data
- reg_we_i  in  1  write-back enable
- reg_waddr_i  in  5  write-back register
- mem_addr_i  in  32  effective address (op1+op2)
- reg2_rdata_i  in  32  store data (rs2)
- bus_gnt_i  in  1  bus grant
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  read data
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word-aligned address
- bus_wdata_o  out  32  write data
- bus_be_o  out  4  byte enables
- reg_wdata_o  out  32  write-back data
- reg_we_o  out  1  write-back enable
- reg_waddr_o  out  5  write-back register
- stall_o  out  1  hold EX/MEM inputs stable
- misalign_o  out  1  1-cycle pulse on misaligned access
- bus_err_o  out  1  1-cycle pulse on timeout abort

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, timeout counter 0, every output 0. Reset mid-transaction drops bus_req_o immediately. No retry after reset.
- Decode:
  - Load = opcode 0000011. funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store = opcode 0100011. funct3 000 SB, 001 SH, 010 SW.
  - Any other funct3 under these opcodes is a bubble: reg_we_o<=0, no bus access, no flag.
- Misaligned: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0.
- States: IDLE, REQ, WAIT_R, DONE.
- stall_o (combinational) = (IDLE & aligned mem op) | REQ | WAIT_R. It is 0 in DONE.
- IDLE, non-mem instruction: next edge reg_*_o <= reg_*_i. Stay IDLE. Throughput 1/cycle, latency 1.
- IDLE, misaligned mem op: next edge misalign_o=1 for one cycle, reg_we_o<=0. Stay IDLE, no bus access.
- IDLE, aligned mem op: next edge go to REQ. At that edge, register:
  - bus_addr_o = {addr[31:2],2'b00}
  - bus_we_o = store
  - byte offset addr[1:0], load type, reg_waddr_i, reg_we_i
  - bus_wdata_o: SB {4{rs2[7:0]}}; SH {2{rs2[15:0]}}; SW rs2
  - bus_be_o: SB 0001<<addr[1:0]; SH addr[1]?1100:0011; SW 1111. Loads drive bus_be_o the same way.
  - Counter cleared; reg_we_o<=0.
- REQ: bus_req_o=1, held with stable addr/data/be until bus_gnt_i=1. On the gnt edge:
  - Store: go to DONE, reg_we_o<=0.
  - Load: go to WAIT_R, bus_req_o<=0, counter cleared.
- WAIT_R: wait for bus_rvalid_i. On that edge go to DONE with:
  - reg_wdata_o = extracted field: byte = rdata>>(8*off), half = rdata>>(8*off).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
  - reg_we_o<=latched we, reg_waddr_o<=latched waddr.
- bus_rvalid_i outside WAIT_R is ignored. bus_gnt_i outside REQ is ignored.
- DONE: result visible for exactly this cycle; stall_o=0, so upstream advances at the edge. Next edge go to IDLE with reg_we_o<=0.
- Timeout: in REQ/WAIT_R the counter increments every cycle. If it reaches TIMEOUT≠0 before the handshake: bus_req_o<=0, bus_err_o pulses 1 cycle, reg_we_o<=0, go to DONE.
- Simultaneous gnt and counter expiry: the handshake wins.

Test Plan:
- ADD x5 (reg_we_i=1, reg_waddr_i=5, wdata 0x1234) for 3 consecutive cycles -> reg_we_o=1, reg_waddr_o=5, reg_wdata_o=0x1234 one cycle later; stall_o never asserted.
- SB, addr 0x1003, rs2 0xAABBCC80, gnt after 2 cycles -> bus_addr_o=0x1000, bus_be_o=1000, bus_wdata_o=0x80808080, bus_we_o=1; req held 3 cycles; reg_we_o=0; stall_o drops in DONE.
- LB addr 0x2002, rdata 0x00F00000, rvalid 1 cycle after gnt -> reg_wdata_o=0xFFFFFFF0, reg_we_o=1 for exactly one cycle. LBU same stimulus -> reg_wdata_o=0x000000F0.
- LH addr 0x2001 -> misalign_o pulses once, bus_req_o stays 0, stall_o=0. LW addr 0x2004 -> normal access.
- TIMEOUT=4, store with gnt never asserted -> bus_req_o high for 4 cycles, bus_err_o pulses once, reg_we_o=0, block returns to IDLE.
- rst driven 0 while in WAIT_R -> all outputs 0 immediately. A late rvalid after reset release is ignored; the next ADD completes in 1 cycle.
